// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - 2x2 stride-2 signed max pooling over a raster pixel stream
module maxpool2x2_stream #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = IMG_W / 2;
  localparam int AW = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic signed [WIDTH-1:0] hreg;
  logic signed [WIDTH-1:0] pix;
  logic signed [WIDTH-1:0] m;
  logic signed [WIDTH-1:0] above;
  logic signed [WIDTH-1:0] pooled;
  logic signed [WIDTH-1:0] linebuf [HW];
  logic [AW-1:0]           lb_idx;
  logic                    in_xfer;
  logic                    out_xfer;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  assign pix    = in_data;
  assign lb_idx = AW'(col >> 1);
  assign m      = (pix > hreg) ? pix : hreg;
  assign above  = linebuf[lb_idx];
  assign pooled = (m > above) ? m : above;

  // Horizontal pair maxima from even rows wait here for the odd row below.
  always_ff @(posedge clk) begin
    if (!resetn && in_xfer && col[0] && !row[0]) begin
      linebuf[lb_idx] <= m;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      col       <= '0;
      row       <= '0;
      hreg      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (in_xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        // A load in the same cycle as an output transfer overrides the clear above.
        if (!col[0]) begin
          hreg <= pix;
        end else if (row[0]) begin
          out_data  <= pooled;
          out_valid <= 1'b1;
          out_last  <= (row == ROW_LAST) && (col == COL_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - scoreboard bench for maxpool2x2_stream (4x4 and 8x8 instances)
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_last4;
  logic [15:0] in_data4 = '0, out_data4;
  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, out_last8;
  logic [15:0] in_data8 = '0, out_data8;

  int total = 0;
  int bad   = 0;
  int q_d4[$];
  bit q_l4[$];
  int q_d8[$];
  bit q_l8[$];

  int f_seq[16];
  int f_sgn[16] = '{-128, -1, -5, -5,
                    -7, -300, -5, -5,
                    100, -200, 32767, -32768,
                    99, 101, 0, -1};
  int f_b[16]   = '{3, -3, 8, 2,
                    -4, 1, -9, -10,
                    -32768, -32767, 7, 7,
                    -32768, -32768, 6, 9};
  int img8[64];

  maxpool2x2_stream #(.WIDTH(16), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .resetn(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4)
  );

  maxpool2x2_stream #(.WIDTH(16), .IMG_W(8), .IMG_H(8)) u8 (
    .clk(clk), .resetn(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_last(out_last8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors sample just after the falling edge so same-edge stimulus changes have settled.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid4 && out_ready4) begin
      if (q_d4.size() == 0) chk("unexpected_out4", 1, 0);
      else begin
        chk("out4_data", int'($signed(out_data4)), q_d4.pop_front());
        chk("out4_last", int'(out_last4), int'(q_l4.pop_front()));
      end
    end
    if (!rst && out_valid8 && out_ready8) begin
      if (q_d8.size() == 0) chk("unexpected_out8", 1, 0);
      else begin
        chk("out8_data", int'($signed(out_data8)), q_d8.pop_front());
        chk("out8_last", int'(out_last8), int'(q_l8.pop_front()));
      end
    end
  end

  task automatic expect4(input int d, input bit l);
    q_d4.push_back(d);
    q_l4.push_back(l);
  endtask

  task automatic push(input bit big, input int px);
    int n = 0;
    if (big) begin in_valid8 = 1'b1; in_data8 = 16'(px); end
    else     begin in_valid4 = 1'b1; in_data4 = 16'(px); end
    #1;
    while (!(big ? in_ready8 : in_ready4) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    if (big) in_valid8 = 1'b0;
    else     in_valid4 = 1'b0;
  endtask

  task automatic send4(input int px[16], input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push(1'b0, px[i]);
    end
  endtask

  initial begin
    int n;
    int hold_d;
    int hold_l;
    int mx;
    for (int i = 0; i < 16; i++) f_seq[i] = i;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid4", int'(out_valid4), 0);
    chk("rst_data4", int'(out_data4), 0);
    chk("rst_last4", int'(out_last4), 0);
    chk("rst_ready4", int'(in_ready4), 1);
    chk("rst_valid8", int'(out_valid8), 0);

    // Sequential frame with per-pixel latency checks
    expect4(5, 0); expect4(7, 0); expect4(13, 0); expect4(15, 1);
    for (int i = 0; i < 16; i++) begin
      push(1'b0, i);
      chk("lat_valid", int'(out_valid4), int'(i == 5 || i == 7 || i == 13 || i == 15));
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        chk("lat_data", int'($signed(out_data4)), i);
        chk("lat_last", int'(out_last4), int'(i == 15));
      end
    end

    // Signed windows, then a second frame, with random input gaps
    expect4(-1, 0); expect4(-5, 0); expect4(101, 0); expect4(32767, 1);
    expect4(3, 0); expect4(8, 0); expect4(-32767, 0); expect4(9, 1);
    send4(f_sgn, 1'b1);
    send4(f_b, 1'b1);

    // Backpressure: stall the first pooled output for five cycles
    expect4(5, 0); expect4(7, 0); expect4(13, 0); expect4(15, 1);
    fork
      send4(f_seq, 1'b0);
      begin
        n = 0;
        while (!out_valid4 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("stall_wait_timeout", 0, 1);
        out_ready4 = 1'b0;
        #1;
        hold_d = int'($signed(out_data4));
        hold_l = int'(out_last4);
        repeat (5) begin
          @(negedge clk);
          #1;
          chk("stall_in_ready", int'(in_ready4), 0);
          chk("stall_valid", int'(out_valid4), 1);
          chk("stall_data", int'($signed(out_data4)), hold_d);
          chk("stall_last", int'(out_last4), hold_l);
        end
        @(negedge clk);
        out_ready4 = 1'b1;
      end
    join

    // Mid-frame reset after six pixels; a pixel offered during reset must be ignored
    expect4(5, 0);
    for (int i = 0; i < 6; i++) push(1'b0, i);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    in_valid4 = 1'b1;
    in_data4 = 16'd99;
    @(negedge clk);
    rst = 1'b0;
    in_valid4 = 1'b0;
    chk("mid_rst_valid", int'(out_valid4), 0);
    chk("mid_rst_data", int'(out_data4), 0);
    chk("mid_rst_last", int'(out_last4), 0);
    expect4(5, 0); expect4(7, 0); expect4(13, 0); expect4(15, 1);
    send4(f_seq, 1'b0);

    // 8x8 random signed frame against a window-max reference
    for (int i = 0; i < 64; i++) img8[i] = int'($signed(16'($urandom_range(0, 65535))));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mx = img8[16*r + 2*c];
        if (img8[16*r + 2*c + 1] > mx) mx = img8[16*r + 2*c + 1];
        if (img8[16*r + 8 + 2*c] > mx) mx = img8[16*r + 8 + 2*c];
        if (img8[16*r + 9 + 2*c] > mx) mx = img8[16*r + 9 + 2*c];
        q_d8.push_back(mx);
        q_l8.push_back(r == 3 && c == 3);
      end
    end
    for (int i = 0; i < 64; i++) push(1'b1, img8[i]);

    n = 0;
    while ((q_d4.size() != 0 || q_d8.size() != 0) && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("q4_drained", q_d4.size(), 0);
    chk("q8_drained", q_d8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Downstream stage of a convolution filter layer.
- Consumes one channel's raster-ordered filter output stream and applies 2x2, stride-2 signed max pooling.
- Emits the pooled stream with a valid/ready handshake.
- Instantiate one per output channel, between filter layers or before the classifier.

Parameters:
- WIDTH, 16: bit width of signed input/output samples.
- IMG_W, 8: input feature-map width in pixels; even, >=2.
- IMG_H, 8: input feature-map height in pixels; even, >=2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- resetn  input  1  synchronous, active-high reset. Asserted = 1. The name is kept for codebase consistency.
- in_valid  input  1  in_data carries a pixel.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  WIDTH  signed filter output pixel, raster order (row-major, col 0 first).
- out_valid  output  1  out_data holds a pooled pixel.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  signed pooled pixel.
- out_last  output  1  qualifies out_data as the final pooled pixel of the frame.

Behaviour:
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Ready: in_ready = !out_valid || out_ready. Combinational from out_ready; no other path to in_ready.
- Counters:
  - col counts 0..IMG_W-1; row counts 0..IMG_H-1.
  - Both advance only on input transfer.
  - col wraps to 0 and increments row; row wraps to 0 after (IMG_H-1, IMG_W-1).
  - No idle gap between frames.
- Per input transfer:
  - col even: hreg <= in_data.
  - col odd: m = signed max(hreg, in_data).
  - row even and col odd: linebuf[col>>1] <= m. linebuf is IMG_W/2 entries of WIDTH bits.
  - row odd and col odd: out_data <= signed max(linebuf[col>>1], m); out_valid <= 1; out_last <= (row==IMG_H-1 && col==IMG_W-1).
- Latency: the pooled result is registered on the edge that accepts the 4th pixel of the window, so it is visible the next cycle.
- Output register:
  - On output transfer without a new load: out_valid <= 0, out_last <= 0. out_data holds its value.
  - Output transfer and a new load in the same cycle: load wins; out_valid stays 1.
  - While out_valid && !out_ready, in_ready = 0, so no input is lost and out_data/out_last stay stable.
- Arithmetic:
  - Two's-complement compare, no saturation, no width growth.
  - Ties select either operand; the value is identical.
- Output rate: one pooled pixel per two input pixels on odd rows; none on even rows.
- Reset (resetn=1 at an edge):
  - col=0, row=0, hreg=0, out_valid=0, out_data=0, out_last=0.
  - linebuf is not reset; it is always written before it is read.
  - A mid-frame reset discards the partial frame. The next accepted pixel is (0,0) of a new frame.
  - Reset overrides a simultaneous input transfer.
- The block does not check the upstream frame length. The counters alone define the frame.

Test Plan:
- IMG_W=4, IMG_H=4, in_data 0..15 row-major, out_ready=1 -> outputs 5, 7, 13, 15 in order; out_last=1 only with 15; each appears one cycle after pixels 5, 7, 13, 15 are accepted.
- Signed data, 4x4: window values {-128, -1, -7, -300} -> -1. All-equal window of -5 -> -5.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_data/out_last stable, no pixels dropped. After release, full output sequence matches the no-stall run.
- Random in_valid gaps plus two back-to-back 4x4 frames -> second frame's outputs correct. Counters wrap with no bubble. out_last pulses once per frame.
- Assert resetn for 1 cycle after 6 accepted pixels, then send a full 4x4 frame of 0..15 -> outputs exactly 5, 7, 13, 15. All outputs read 0/low in the cycle after reset.
- Default IMG_W=8, IMG_H=8, random signed data vs. reference model -> 16 outputs match bit-exactly.
